// File: rtl/chip_clk_seq.sv
// ---------------------------------------------------------------------------
// chip_clk_seq
//
// Produces the per-chip 25 MHz clock-enable vector that gates the chip clock
// DDR outputs.
//
// Sequence of operation:
//   - Wait for the PLL lock to be seen after synchronisation.
//   - Wait a settle window of LOCK_WAIT cycles.
//   - Turn requested chip clocks on one at a time, lowest index first.
//     Successive turn-ons are spaced STAGGER+1 cycles apart to limit supply
//     inrush.
//   - Turn-offs take effect on the next edge.
//   - Losing lock forces every enable off and restarts the whole sequence.
//
// Parameters:
//   N_CHIP     number of chip clock enables
//   LOCK_WAIT  cycles the synchronised lock must stay high before any enable
//              (1..65535)
//   STAGGER    idle cycles between successive turn-ons (0..65535)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   pll_locked  PLL lock, asynchronous; passed through a 2-flop synchroniser
//   en_req      requested enable mask from the MCU register block
//   clk25m_on   registered chip clock enables
//   busy        sequencing in progress or not yet running
//   seq_done    running and every requested bit is on
//   loss_cnt    lock-loss event count (zero unless the feature is built)
//   loss_clr    clears loss_cnt (ignored unless the feature is built)
//
// Optional feature macro: CHIP_CLK_LOSSCNT_EN
//   When defined, loss_cnt counts RUN-to-WAIT_LOCK transitions caused by lock
//   loss. The count saturates at 255, and loss_clr has priority over an
//   increment in the same cycle.
//   When undefined, loss_cnt is tied to zero.
// ---------------------------------------------------------------------------
module chip_clk_seq #(
  parameter int N_CHIP    = 8,
  parameter int LOCK_WAIT = 1024,
  parameter int STAGGER   = 250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic [N_CHIP-1:0] en_req,
  output logic [N_CHIP-1:0] clk25m_on,
  output logic              busy,
  output logic              seq_done,
  output logic [7:0]        loss_cnt,
  input  logic              loss_clr
);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  localparam logic [15:0] SettleLoad = 16'(LOCK_WAIT - 1);
  localparam logic [15:0] GapLoad    = 16'(STAGGER);

  logic              syncMeta_q;
  logic              lockedS_q;

  state_t            state_q, state_d;
  logic [N_CHIP-1:0] on_q, on_d;
  logic [15:0]       settle_q, settle_d;
  logic [15:0]       gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [N_CHIP-1:0] pending;
  logic [N_CHIP-1:0] lowestPending;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta_q <= 1'b0;
      lockedS_q  <= 1'b0;
    end else begin
      syncMeta_q <= pll_locked;
      lockedS_q  <= syncMeta_q;
    end
  end

  // Bits that are requested but not yet on. The lowest one is isolated with
  // the two's-complement trick so that turn-ons go in ascending index order.
  assign pending       = en_req & ~on_q;
  assign lowestPending = pending & (~pending + N_CHIP'(1));

  // Next-state logic. A synchronised lock loss overrides everything, so it is
  // applied last. busy/seq_done look at the next state but at the pending set
  // of this cycle. As a result, seq_done rises one cycle after the final
  // enable lands.
  always_comb begin
    state_d  = state_q;
    on_d     = on_q;
    settle_d = settle_q;
    gap_d    = gap_q;

    unique case (state_q)
      WAIT_LOCK: begin
        on_d = '0;
        if (lockedS_q) begin
          settle_d = SettleLoad;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        on_d = '0;
        if (settle_q != '0) begin
          settle_d = settle_q - 16'd1;
        end else begin
          state_d = RUN;
          gap_d   = '0;
        end
      end
      RUN: begin
        on_d = on_q & en_req;
        if ((pending != '0) && (gap_q == '0)) begin
          on_d  = on_d | lowestPending;
          gap_d = GapLoad;
        end else if (gap_q != '0) begin
          gap_d = gap_q - 16'd1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        on_d    = '0;
      end
    endcase

    if (!lockedS_q) begin
      state_d  = WAIT_LOCK;
      on_d     = '0;
      settle_d = '0;
      gap_d    = '0;
    end

    busy_d = (state_d != RUN) || (pending != '0);
    done_d = (state_d == RUN) && (pending == '0);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WAIT_LOCK;
      on_q     <= '0;
      settle_q <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_q     <= on_d;
      settle_q <= settle_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign clk25m_on = on_q;
  assign busy      = busy_q;
  assign seq_done  = done_q;

`ifdef CHIP_CLK_LOSSCNT_EN
  logic [7:0] loss_q;

  // Count lock losses seen while running. A clear wins over an increment in
  // the same cycle, and the count sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_clr) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && !lockedS_q && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign loss_cnt = loss_q;
`else
  logic unusedLossClr;

  assign unusedLossClr = loss_clr;
  assign loss_cnt      = '0;
`endif

endmodule

// File: tb/tb_chip_clk_seq.sv
// ---------------------------------------------------------------------------
// tb_chip_clk_seq
//
// Self-checking bench for chip_clk_seq with LOCK_WAIT=16 and STAGGER=4.
//
// The reference model does not track an FSM. Instead it uses:
//   - a run of consecutive synchronised-lock cycles, which decides whether
//     the block is running;
//   - the time of the next permitted turn-on, which decides when the next
//     pending bit may switch on.
//
// The bench applies a table of hand-derived checkpoints, then hand-written
// lock-loss and reset sequences, then random traffic, and finally (when
// CHIP_CLK_LOSSCNT_EN is defined) the lock-loss counter scenarios.
// ---------------------------------------------------------------------------
module tb_chip_clk_seq;

  localparam int N  = 8;
  localparam int LW = 16;
  localparam int ST = 4;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       loss_clr   = 1'b0;
  logic [7:0] en_req     = 8'h00;
  logic [7:0] clk25m_on;
  logic       busy;
  logic       seq_done;
  logic [7:0] loss_cnt;

  chip_clk_seq #(
    .N_CHIP   (N),
    .LOCK_WAIT(LW),
    .STAGGER  (ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .en_req    (en_req),
    .clk25m_on (clk25m_on),
    .busy      (busy),
    .seq_done  (seq_done),
    .loss_cnt  (loss_cnt),
    .loss_clr  (loss_clr)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state
  logic       mSync1;
  logic       mLs;
  int         mStreak;
  logic [7:0] mOn;
  logic       mBusy;
  logic       mDone;
  int         mLoss;
  int         mCycle;
  int         mNextAllowed;

  typedef struct {
    logic       pll;
    logic [7:0] en;
    int         adv;
    logic [7:0] expOn;
    logic       expBusy;
    logic       expDone;
  } vec_t;

  vec_t tbl [14];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mSync1       = 1'b0;
    mLs          = 1'b0;
    mStreak      = 0;
    mOn          = 8'h00;
    mBusy        = 1'b1;
    mDone        = 1'b0;
    mLoss        = 0;
    mNextAllowed = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  // The block is running in a cycle when the synchronised lock was high for
  // each of the previous LW+1 cycles.
  task automatic modelStep();
    logic       runNow;
    logic       runNext;
    int         streakNew;
    logic [7:0] pend;
    logic [7:0] onNew;
    logic       found;

    runNow    = (mStreak >= LW + 1);
    streakNew = mLs ? ((mStreak < 1000000) ? mStreak + 1 : mStreak) : 0;
    runNext   = (streakNew >= LW + 1);
    pend      = en_req & ~mOn;
    onNew     = 8'h00;
    found     = 1'b0;
    if (!runNow) mNextAllowed = 0;
    if (runNow && mLs) begin
      onNew = mOn & en_req;
      if ((pend != 8'h00) && (mCycle >= mNextAllowed)) begin
        for (int b = 0; b < N; b++) begin
          if (pend[b] && !found) begin
            onNew[b]     = 1'b1;
            found        = 1'b1;
            mNextAllowed = mCycle + ST + 1;
          end
        end
      end
    end
`ifdef CHIP_CLK_LOSSCNT_EN
    if (loss_clr) mLoss = 0;
    else if (runNow && !mLs && (mLoss < 255)) mLoss = mLoss + 1;
`else
    mLoss = 0;
`endif
    mBusy   = !runNext || (pend != 8'h00);
    mDone   = runNext && (pend == 8'h00);
    mOn     = onNew;
    mStreak = streakNew;
    mLs     = mSync1;
    mSync1  = pll_locked;
    mCycle++;
  endtask

  task automatic applyStimulus(input logic pll, input logic [7:0] en, input logic clr);
    pll_locked = pll;
    en_req     = en;
    loss_clr   = clr;
  endtask

  task automatic checkOutput();
    compare($sformatf("model cycle %0d", mCycle),
            {14'd0, clk25m_on, busy, seq_done, loss_cnt},
            {14'd0, mOn, mBusy, mDone, 8'(mLoss)});
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Called at posedge+1. Asserts reset between edges, checks that the
  // outputs clear at once, and releases reset away from an edge.
  task automatic doReset(input string name);
    #2 rst_n = 1'b0;
    #1;
    compare(name, {14'd0, clk25m_on, busy, seq_done, loss_cnt},
            {14'd0, 8'h00, 1'b1, 1'b0, 8'h00});
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    int holdLow;

    tbl[0]  = '{1'b1, 8'hFF, 1,  8'h00, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 18, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 1,  8'h01, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 8'hFF, 4,  8'h01, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 8'hFF, 1,  8'h03, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 8'hFF, 10, 8'h0F, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 8'hFF, 20, 8'hFF, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 8'hFF, 1,  8'hFF, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'hF0, 1,  8'hF0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 8'h00, 3,  8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 8'h05, 1,  8'h01, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 8'h05, 4,  8'h01, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'h05, 1,  8'h05, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 8'h05, 1,  8'h05, 1'b0, 1'b1};

    // Power-on reset
    #12;
    compare("reset values", {14'd0, clk25m_on, busy, seq_done, loss_cnt},
            {14'd0, 8'h00, 1'b1, 1'b0, 8'h00});
    modelReset();
    mCycle = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Table-driven power-up and run-mode checkpoints
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i].pll, tbl[i].en, 1'b0);
      repeat (tbl[i].adv) tick();
      compare($sformatf("table %0d", i), {29'd0, clk25m_on, busy, seq_done},
              {29'd0, tbl[i].expOn, tbl[i].expBusy, tbl[i].expDone});
    end

    // Lock loss mid-sequence, then full relock and restart from bit 0
    applyStimulus(1'b1, 8'hFF, 1'b0);
    lat = 0;
    while ((clk25m_on !== 8'h07) && (lat < 40)) begin
      tick();
      lat++;
    end
    compare("reach bits 0..2", {24'd0, clk25m_on}, 32'h07);
    applyStimulus(1'b0, 8'hFF, 1'b0);
    lat = 0;
    while ((clk25m_on !== 8'h00) && (lat < 6)) begin
      tick();
      lat++;
    end
    compare("lock drop latency", lat, 3);
    compare("busy after lock drop", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    lat = 0;
    while ((clk25m_on === 8'h00) && (lat < 100)) begin
      tick();
      lat++;
    end
    compare("relock to first enable", lat, 20);
    compare("restart at bit 0", {24'd0, clk25m_on}, 32'h01);

    // Asynchronous reset while running with all enables on
    lat = 0;
    while ((seq_done !== 1'b1) && (lat < 100)) begin
      tick();
      lat++;
    end
    compare("all on before reset", {24'd0, clk25m_on}, 32'hFF);
    doReset("async reset in RUN");

    // Asynchronous reset during SETTLE, then a fresh lock and settle
    repeat (8) tick();
    doReset("async reset in SETTLE");
    lat = 0;
    while ((clk25m_on === 8'h00) && (lat < 100)) begin
      tick();
      lat++;
    end
    compare("post-reset first enable", lat, 20);

    // Random traffic against the model
    holdLow = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) en_req = 8'($urandom);
      if (holdLow > 0) begin
        holdLow--;
        pll_locked = (holdLow == 0);
      end else if ($urandom_range(0, 149) == 0) begin
        holdLow    = $urandom_range(1, 6);
        pll_locked = 1'b0;
      end
      loss_clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    applyStimulus(1'b1, 8'hFF, 1'b0);

`ifdef CHIP_CLK_LOSSCNT_EN
    // Lock-loss counter scenarios
    repeat (2) tick();
    doReset("reset before loss count");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'h0F, 1'b0);
      repeat (25) tick();
      applyStimulus(1'b0, 8'h0F, 1'b0);
      repeat (4) tick();
    end
    compare("loss count after 3", {24'd0, loss_cnt}, 32'd3);
    applyStimulus(1'b1, 8'h0F, 1'b0);
    repeat (8) tick();
    applyStimulus(1'b0, 8'h0F, 1'b0);
    repeat (4) tick();
    compare("no count from SETTLE", {24'd0, loss_cnt}, 32'd3);
    applyStimulus(1'b0, 8'h0F, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h0F, 1'b0);
    tick();
    compare("loss clear", {24'd0, loss_cnt}, 32'd0);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b1, 8'h0F, 1'b0);
      repeat (22) tick();
      applyStimulus(1'b0, 8'h0F, 1'b0);
      repeat (3) tick();
    end
    compare("loss count saturates", {24'd0, loss_cnt}, 32'd255);
`else
    compare("loss count tied off", {24'd0, loss_cnt}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
